// File: rtl/mem_responder.sv
// Single-port memory responder with a req/ready handshake, per-byte write strobes and error responses.
// Optional wait states are built when MEM_WAITSTATE_EN is defined.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

`ifdef MEM_WAITSTATE_EN
  localparam bit WAIT_EN = (WAIT_CYCLES > 0);
`else
  // WAIT_CYCLES has no effect in this build; ST_WAIT is unreachable.
  localparam bit WAIT_EN = 1'b0 && (WAIT_CYCLES > 0);
`endif

  // Handshake: the requester holds req and all fields stable until it samples ready=1;
  // ready is a one-cycle pulse decoded from the RESP state, rdata/err are valid with it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

`ifdef MEM_WAITSTATE_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
`endif

  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        op_we;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [3:0]  op_wstrb;
  logic        addr_err;
  logic        commit;
  logic [IDX_W-1:0] word_idx;

  logic [31:0] mem [DEPTH_WORDS];

  // With no wait states the commit edge is the acceptance edge, so the live port values are used.
  always_comb begin
`ifdef MEM_WAITSTATE_EN
    if (state_q == ST_IDLE) begin
      op_we    = we;
      op_addr  = addr;
      op_wdata = wdata;
      op_wstrb = wstrb;
    end else begin
      op_we    = we_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
      op_wstrb = wstrb_q;
    end
`else
    op_we    = we;
    op_addr  = addr;
    op_wdata = wdata;
    op_wstrb = wstrb;
`endif
  end

  assign addr_err = (op_addr[1:0] != 2'b00) ||
                    ({2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign word_idx = op_addr[IDX_W+1:2];

  always_comb begin
    state_d = state_q;
`ifdef MEM_WAITSTATE_EN
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = WAIT_EN ? ST_WAIT : ST_RESP;
`ifdef MEM_WAITSTATE_EN
          cnt_d   = 8'(WAIT_CYCLES - 1);
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          wstrb_d = wstrb;
`endif
        end
      end
`ifdef MEM_WAITSTATE_EN
      ST_WAIT: begin
        if (cnt_q == 8'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 8'd1;
      end
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // An edge seen while reset is asserted never commits.
  assign commit = rst_n && (state_q != ST_RESP) && (state_d == ST_RESP);

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      err_d   = addr_err;
      rdata_d = (addr_err || op_we) ? 32'h0 : mem[word_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
`ifdef MEM_WAITSTATE_EN
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef MEM_WAITSTATE_EN
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (commit && op_we && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (op_wstrb[i]) mem[word_idx][8*i +: 8] <= op_wdata[8*i +: 8];
      end
    end
  end

  assign ready = (state_q == ST_RESP);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule
